// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, response record and control-code legality check.
package alu_pkg;

  localparam int ALU_XLEN   = 32;
  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SLTU = 4'h9
  } alu_ctrl_e;

  // One response slot: result, flags {Z,N,V,C} and the unsupported-code marker.
  typedef struct packed {
    logic [ALU_XLEN-1:0] result;
    logic [3:0]          flags;
    logic                err;
  } alu_rsp_t;

  function automatic logic alu_ctrl_legal(input logic [ALU_CTRL_W-1:0] ctrl);
    return ctrl <= 4'h9;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. C and V are produced only by ADD/SUB; unsupported codes yield 0 and err.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_XLEN-1:0]   a_i,
  input  logic [ALU_XLEN-1:0]   b_i,
  input  logic [ALU_CTRL_W-1:0] ctrl_i,
  output alu_rsp_t              rsp_o
);

  logic [ALU_XLEN:0]   sum;
  logic [ALU_XLEN-1:0] res;
  logic                c;
  logic                v;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    sum = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (alu_ctrl_e'(ctrl_i))
      ALU_ADD: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        res = sum[ALU_XLEN-1:0];
        c   = sum[ALU_XLEN];
        v   = (a_i[ALU_XLEN-1] == b_i[ALU_XLEN-1]) && (res[ALU_XLEN-1] != a_i[ALU_XLEN-1]);
      end
      // Subtract as A + ~B + 1, so C is the no-borrow indication.
      ALU_SUB: begin
        sum = {1'b0, a_i} + {1'b0, ~b_i} + {{ALU_XLEN{1'b0}}, 1'b1};
        res = sum[ALU_XLEN-1:0];
        c   = sum[ALU_XLEN];
        v   = (a_i[ALU_XLEN-1] != b_i[ALU_XLEN-1]) && (res[ALU_XLEN-1] != a_i[ALU_XLEN-1]);
      end
      ALU_AND:  res = a_i & b_i;
      ALU_OR:   res = a_i | b_i;
      ALU_XOR:  res = a_i ^ b_i;
      ALU_SLT:  res = {{(ALU_XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLL:  res = a_i << b_i[4:0];
      ALU_SRA:  res = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_SRL:  res = a_i >> b_i[4:0];
      ALU_SLTU: res = {{(ALU_XLEN-1){1'b0}}, (a_i < b_i)};
      default:  res = '0;
    endcase
    rsp_o.result = res;
    rsp_o.flags  = {(res == '0), res[ALU_XLEN-1], v, c};
    rsp_o.err    = !alu_ctrl_legal(ctrl_i);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from the requester after the last winner; one-hot grant.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] elig_i,
  output logic [N-1:0] grant_o
);

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant_o = '0;
    last_d  = last_q;
    cand    = '0;
    found   = 1'b0;
    if (!rst) begin
      for (int off = 1; off <= N; off++) begin
        cand = IW'((int'(last_q) + off) % N);
        if (!found && elig_i[cand]) begin
          grant_o[cand] = 1'b1;
          last_d        = cand;
          found         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    if (rst) last_q <= IW'(N - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, one registered response slot per requester.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]    req_ctrl,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [NUM_REQ*XLEN-1:0] rsp_result,
  output logic [NUM_REQ*4-1:0]    rsp_flags,
  output logic [NUM_REQ-1:0]      rsp_err
);

  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    grant;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  alu_rsp_t              alu_rsp;

  logic [NUM_REQ-1:0] valid_q;
  logic [NUM_REQ-1:0] valid_d;
  alu_rsp_t           slot_q [NUM_REQ];
  alu_rsp_t           slot_d [NUM_REQ];

  // A full slot being drained this cycle may take a new operation in the same cycle.
  assign elig = req_valid & (~valid_q | rsp_ready);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .elig_i  (elig),
    .grant_o (grant)
  );

  assign req_ready = grant;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_a    = req_a[i*XLEN +: XLEN];
        alu_b    = req_b[i*XLEN +: XLEN];
        alu_ctrl = req_ctrl[i*4 +: 4];
      end
    end
  end

  alu u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .ctrl_i (alu_ctrl),
    .rsp_o  (alu_rsp)
  );

  // Per slot: a grant loads, otherwise a drain clears valid, otherwise hold.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_d[i]  = slot_q[i];
      valid_d[i] = valid_q[i];
      if (grant[i]) begin
        slot_d[i]  = alu_rsp;
        valid_d[i] = 1'b1;
      end else if (rsp_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: slot contents are reset as well, because result/flags/err must read 0 out of reset.
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    rsp_valid = valid_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_result[i*XLEN +: XLEN] = slot_q[i].result;
      rsp_flags[i*4 +: 4]        = slot_q[i].flags;
      rsp_err[i]                 = slot_q[i].err;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a behavioural reference model.
module tb_alu_share_arbiter;

  localparam int N = 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a;
  logic [N*32-1:0]   req_b;
  logic [N*4-1:0]    req_ctrl;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [N*32-1:0]   rsp_result;
  logic [N*4-1:0]    rsp_flags;
  logic [N-1:0]      rsp_err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  bit          mv   [N];
  logic [31:0] mres [N];
  logic [3:0]  mfl  [N];
  logic        merr [N];
  int          mlast;
  logic [N-1:0] seen_ready;

  alu_share_arbiter #(.NUM_REQ(N), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ALU behaviour from arithmetic rules on wide integers.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output logic e);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint sa = $signed(a);
    longint sb = $signed(b);
    bit c = 1'b0;
    bit v = 1'b0;
    e = 1'b0;
    case (op)
      4'h0: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; v = (sa + sb > SMAX) || (sa + sb < SMIN); end
      4'h1: begin r = a - b; c = (ua >= ub); v = (sa - sb > SMAX) || (sa - sb < SMIN); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h6: r = a << b[4:0];
      4'h7: r = 32'(sa >>> b[4:0]);
      4'h8: r = a >> b[4:0];
      4'h9: r = (ua < ub) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    f = {(r == 32'd0), r[31], v, c};
  endfunction

  task automatic set_req(input int i, input logic v, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = v;
    req_ctrl[i*4 +: 4] = c;
    req_a[i*32 +: 32]  = a;
    req_b[i*32 +: 32]  = b;
  endtask

  task automatic rand_req(input int i);
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    if ($urandom_range(0, 3) == 0) a = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) b = 32'h8000_0000;
    set_req(i, 1'b1, 4'($urandom_range(0, 15)), a, b);
  endtask

  // One clock: check req_ready before the edge, advance the model, check slots after the edge.
  task automatic cycle();
    logic [N-1:0] exp_ready = '0;
    logic [31:0] r;
    logic [3:0]  f;
    logic        e;
    #1;
    if (!rst) begin
      for (int k = 1; k <= N; k++) begin
        int i = (mlast + k) % N;
        if (exp_ready == '0 && req_valid[i] && (!mv[i] || rsp_ready[i])) exp_ready[i] = 1'b1;
      end
    end
    seen_ready = req_ready;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mv[i] = 1'b0; mres[i] = '0; mfl[i] = '0; merr[i] = 1'b0;
      end
      mlast = N - 1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (exp_ready[i]) begin
          ref_alu(req_ctrl[i*4 +: 4], req_a[i*32 +: 32], req_b[i*32 +: 32], r, f, e);
          mres[i] = r; mfl[i] = f; merr[i] = e; mv[i] = 1'b1; mlast = i;
        end else if (rsp_ready[i]) begin
          mv[i] = 1'b0;
        end
      end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(mv[i]));
      if (mv[i]) begin
        check($sformatf("rsp_result[%0d]", i), rsp_result[i*32 +: 32], mres[i]);
        check($sformatf("rsp_flags[%0d]", i), 32'(rsp_flags[i*4 +: 4]), 32'(mfl[i]));
        check($sformatf("rsp_err[%0d]", i), 32'(rsp_err[i]), 32'(merr[i]));
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0; rsp_ready = '0;
    for (int i = 0; i < N; i++) begin mv[i] = 1'b0; mres[i] = '0; mfl[i] = '0; merr[i] = 1'b0; end
    mlast = N - 1;
    @(posedge clk); #1;

    // Reset: no grant while rst is high, even with requests present
    req_valid = '1;
    cycle();
    check("rst_ready", 32'(seen_ready), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_result", rsp_result[31:0] | rsp_result[63:32], 32'h0);
    check("rst_flags", 32'(rsp_flags), 32'h0);
    check("rst_err", 32'(rsp_err), 32'h0);
    rst = 1'b0; req_valid = '0; rsp_ready = '1;

    // 1: ADD overflow into the sign bit
    set_req(0, 1'b1, 4'h0, 32'h7FFF_FFFF, 32'h1);
    cycle();
    check("t1_ready", 32'(seen_ready), 32'h1);
    check("t1_result", rsp_result[31:0], 32'h8000_0000);
    check("t1_flags", 32'(rsp_flags[3:0]), 32'h6);
    req_valid = '0;

    // 2: both requesters always valid alternate grants
    for (int k = 0; k < 6; k++) begin
      rand_req(0); rand_req(1);
      cycle();
      check("t2_alternate", 32'(seen_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
    end

    // 3: SUB 5-5 into slot 1, then hold it undrained for 3 cycles
    set_req(1, 1'b1, 4'h1, 32'd5, 32'd5); rand_req(0);
    cycle();
    check("t3_grant1", 32'(seen_ready), 32'h2);
    set_req(1, 1'b1, 4'h7, 32'h8000_0000, 32'd4);
    rsp_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      rand_req(0);
      cycle();
      check("t3_blocked", 32'(seen_ready), 32'h1);
      check("t3_hold_res", rsp_result[63:32], 32'h0);
      check("t3_hold_flg", 32'(rsp_flags[7:4]), 32'h9);
    end

    // 4: drain slot 1 and accept a new SRA in the same cycle
    rsp_ready = 2'b11; rand_req(0);
    cycle();
    check("t4_accept", 32'(seen_ready), 32'h2);
    check("t4_sra", rsp_result[63:32], 32'hF800_0000);

    // 5: unsupported control code, then a legal one
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cycle();
    check("t5_err_res", rsp_result[31:0], 32'h0);
    check("t5_err_flg", 32'(rsp_flags[3:0]), 32'h8);
    check("t5_err", 32'(rsp_err[0]), 32'h1);
    set_req(0, 1'b1, 4'h0, 32'd1, 32'd2);
    cycle();
    check("t5_legal_err", 32'(rsp_err[0]), 32'h0);
    check("t5_legal_res", rsp_result[31:0], 32'd3);

    // 6: reset with full slots and pending requests
    rsp_ready = 2'b00; rand_req(0); rand_req(1);
    cycle(); cycle();
    check("t6_full", 32'(rsp_valid), 32'h3);
    rst = 1'b1;
    cycle();
    check("t6_rst_ready", 32'(seen_ready), 32'h0);
    check("t6_rst_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    cycle();
    check("t6_first_grant", 32'(seen_ready), 32'h1);

    // Randomized traffic with backpressure and occasional reset
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) rand_req(i);
        else req_valid[i] = 1'b0;
        rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end
      rst = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
